// File: rtl/img_stream_pkg.sv
// Shared types and constants for the gray pixel stream source and sink blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package img_stream_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Number of pixels in one raster-order frame.
    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/frame_pixel_streamer_raster_counter.sv
// Raster position counter: col/row/linear address with advance and clear.
// Latency: counters update on the clock edge after adv_i/clr_i; flags are decoded from the registers.
// Backpressure: none; the owner advances only on pixel acceptance.
//
// Ports: clk/rst_n clock and async active-low reset; clr_i returns to (0,0);
// adv_i steps one pixel; col_o/row_o/addr_o current position; first_col_o,
// last_col_o, last_pix_o position flags for the current pixel.
module raster_counter
    import img_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_W       = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               adv_i,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               first_col_o,
    output logic               last_col_o,
    output logic               last_pix_o
);

    localparam int                  FRAME_PIX = frame_size(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam logic [COORD_W-1:0]  COL_LAST  = COORD_W'(IMAGE_WIDTH - 1);
    localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(FRAME_PIX - 1);
    localparam logic [COORD_W-1:0]  COORD_ONE = COORD_W'(1);
    localparam logic [ADDR_W-1:0]   ADDR_ONE  = ADDR_W'(1);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // The linear address is a running count, never row*width+col.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (adv_i) begin
            if (addr_q == ADDR_LAST) begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + ADDR_ONE;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + COORD_ONE;
                end else begin
                    col_d = col_q + COORD_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col_o       = col_q;
    assign row_o       = row_q;
    assign addr_o      = addr_q;
    assign first_col_o = (col_q == '0);
    assign last_col_o  = (col_q == COL_LAST);
    assign last_pix_o  = (addr_q == ADDR_LAST);

endmodule

// File: rtl/frame_pixel_streamer.sv
// Streams one raster-order frame from a sync frame memory onto gray/gray_valid with row/col and markers.
// Latency: start to first gray_valid is 3 cycles; pixel period is 3+GAP_CYCLES cycles with out_ready high.
// Backpressure: out_ready low holds the pixel and all tags in SEND; nothing is dropped or repeated.
//
// Ports: clk/rst_n clock and async active-low reset; start/abort control;
// out_ready downstream accept; mem_rd_en/mem_rd_addr/mem_rd_data frame memory
// read port (1-cycle read latency); gray_valid/gray/pix_row/pix_col pixel out;
// frame_start/line_end/frame_end markers; busy/done status.
module frame_pixel_streamer
    import img_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int GAP_CYCLES   = 3,
    parameter int ADDR_W       = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               out_ready,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [PIX_W-1:0]   mem_rd_data,
    output logic               gray_valid,
    output logic [PIX_W-1:0]   gray,
    output logic [COORD_W-1:0] pix_row,
    output logic [COORD_W-1:0] pix_col,
    output logic               frame_start,
    output logic               line_end,
    output logic               frame_end,
    output logic               busy,
    output logic               done
);

    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q;
    logic [7:0]         gap_cnt_q;
    logic               last_sent_q;
    logic               mem_rd_en_q;
    logic               gray_valid_q;
    logic [PIX_W-1:0]   gray_q;
    logic [COORD_W-1:0] pix_row_q;
    logic [COORD_W-1:0] pix_col_q;
    logic               frame_start_q;
    logic               line_end_q;
    logic               frame_end_q;
    logic               busy_q;
    logic               done_q;

    logic               cnt_clr;
    logic               cnt_adv;
    logic [COORD_W-1:0] cnt_col;
    logic [COORD_W-1:0] cnt_row;
    logic [ADDR_W-1:0]  cnt_addr;
    logic               cnt_first_col;
    logic               cnt_last_col;
    logic               cnt_last_pix;

    // Counters step exactly once per accepted pixel, so stalls cannot skip or repeat.
    assign cnt_adv = (state_q == ST_SEND) && out_ready && !abort;
    assign cnt_clr = abort || ((state_q == ST_IDLE) && start);

    raster_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_raster_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .adv_i      (cnt_adv),
        .col_o      (cnt_col),
        .row_o      (cnt_row),
        .addr_o     (cnt_addr),
        .first_col_o(cnt_first_col),
        .last_col_o (cnt_last_col),
        .last_pix_o (cnt_last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gap_cnt_q     <= '0;
            last_sent_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            gray_valid_q  <= 1'b0;
            gray_q        <= '0;
            pix_row_q     <= '0;
            pix_col_q     <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Read strobe and done are single-cycle; set only on entry to FETCH/DONE.
            mem_rd_en_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort) begin
                state_q       <= ST_IDLE;
                gap_cnt_q     <= '0;
                last_sent_q   <= 1'b0;
                gray_valid_q  <= 1'b0;
                frame_start_q <= 1'b0;
                line_end_q    <= 1'b0;
                frame_end_q   <= 1'b0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q     <= ST_FETCH;
                            mem_rd_en_q <= 1'b1;
                            last_sent_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        // Tags are latched here so they stay put while the counters move on at acceptance.
                        gray_q        <= mem_rd_data;
                        pix_row_q     <= cnt_row;
                        pix_col_q     <= cnt_col;
                        frame_start_q <= cnt_first_col && (cnt_row == '0);
                        line_end_q    <= cnt_last_col;
                        frame_end_q   <= cnt_last_pix;
                        gray_valid_q  <= 1'b1;
                        state_q       <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (out_ready) begin
                            gray_valid_q  <= 1'b0;
                            frame_start_q <= 1'b0;
                            line_end_q    <= 1'b0;
                            frame_end_q   <= 1'b0;
                            last_sent_q   <= cnt_last_pix;
                            if (GAP_CYCLES > 0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= '0;
                            end else if (cnt_last_pix) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= ST_FETCH;
                                mem_rd_en_q <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            if (last_sent_q) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= ST_FETCH;
                                mem_rd_en_q <= 1'b1;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = cnt_addr;
    assign gray_valid  = gray_valid_q;
    assign gray        = gray_q;
    assign pix_row     = pix_row_q;
    assign pix_col     = pix_col_q;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer: 4x3 frame with gap 3 (instance a) and 2x2 frame with gap 0 (instance b).
// Expected pixels are queued when a frame is started and popped as the DUT hands pixels over.
module tb_frame_pixel_streamer;

    localparam int WA = 4, HA = 3, GA = 3, AWA = 4;
    localparam int WB = 2, HB = 2, GB = 0, AWB = 2;

    typedef struct packed {
        logic [7:0]  g;
        logic [15:0] r;
        logic [15:0] c;
        logic        fs;
        logic        le;
        logic        fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a
    logic           start_a, abort_a, ready_a;
    logic           rd_en_a;
    logic [AWA-1:0] rd_addr_a;
    logic [7:0]     mdat_a = 8'd0;
    logic           gv_a, fs_a, le_a, fe_a, busy_a, done_a;
    logic [7:0]     gray_a;
    logic [15:0]    row_a, col_a;

    // Instance b
    logic           start_b, abort_b, ready_b;
    logic           rd_en_b;
    logic [AWB-1:0] rd_addr_b;
    logic [7:0]     mdat_b = 8'd0;
    logic           gv_b, fs_b, le_b, fe_b, busy_b, done_b;
    logic [7:0]     gray_b;
    logic [15:0]    row_b, col_b;

    frame_pixel_streamer #(.IMAGE_WIDTH(WA), .IMAGE_HEIGHT(HA), .GAP_CYCLES(GA), .ADDR_W(AWA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .out_ready(ready_a),
        .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(mdat_a),
        .gray_valid(gv_a), .gray(gray_a), .pix_row(row_a), .pix_col(col_a),
        .frame_start(fs_a), .line_end(le_a), .frame_end(fe_a), .busy(busy_a), .done(done_a)
    );

    frame_pixel_streamer #(.IMAGE_WIDTH(WB), .IMAGE_HEIGHT(HB), .GAP_CYCLES(GB), .ADDR_W(AWB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .out_ready(ready_b),
        .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(mdat_b),
        .gray_valid(gv_b), .gray(gray_b), .pix_row(row_b), .pix_col(col_b),
        .frame_start(fs_b), .line_end(le_b), .frame_end(fe_b), .busy(busy_b), .done(done_b)
    );

    // Frame memories: each word holds its own address, one cycle read latency.
    always @(posedge clk) if (rd_en_a) mdat_a <= {4'b0000, rd_addr_a};
    always @(posedge clk) if (rd_en_b) mdat_b <= {6'b000000, rd_addr_b};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    exp_t qa[$];
    exp_t qb[$];
    int   acc_a[$];
    int   acc_b[$];
    int   addr_b[$];
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;

    function automatic exp_t mk(input int p, input int w, input int h);
        exp_t e;
        e.g  = 8'(p);
        e.r  = 16'(p / w);
        e.c  = 16'(p % w);
        e.fs = (p == 0);
        e.le = ((p % w) == w - 1);
        e.fe = (p == w * h - 1);
        return e;
    endfunction

    task automatic push_frame_a();
        for (int p = 0; p < WA * HA; p++) qa.push_back(mk(p, WA, HA));
    endtask

    task automatic push_frame_b();
        for (int p = 0; p < WB * HB; p++) qb.push_back(mk(p, WB, HB));
    endtask

    // Scoreboard side: compare each accepted pixel against the oldest expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (gv_a && ready_a) begin
            acc_a.push_back(cyc);
            chk("a_sb_has_entry", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_gray", 32'(gray_a), 32'(e.g));
                chk("a_row", 32'(row_a), 32'(e.r));
                chk("a_col", 32'(col_a), 32'(e.c));
                chk("a_frame_start", 32'(fs_a), 32'(e.fs));
                chk("a_line_end", 32'(le_a), 32'(e.le));
                chk("a_frame_end", 32'(fe_a), 32'(e.fe));
            end
        end
        if (done_a) done_cnt_a++;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rd_en_b) addr_b.push_back(int'(rd_addr_b));
        if (gv_b && ready_b) begin
            acc_b.push_back(cyc);
            chk("b_sb_has_entry", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_gray", 32'(gray_b), 32'(e.g));
                chk("b_row", 32'(row_b), 32'(e.r));
                chk("b_col", 32'(col_b), 32'(e.c));
                chk("b_frame_start", 32'(fs_b), 32'(e.fs));
                chk("b_line_end", 32'(le_b), 32'(e.le));
                chk("b_frame_end", 32'(fe_b), 32'(e.fe));
            end
        end
        if (done_b) done_cnt_b++;
    end

    // start is high for the cycle numbered sc; the DUT samples it at the end of that cycle.
    task automatic pulse_start_a(output int sc);
        @(posedge clk); #1;
        start_a = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b(output int sc);
        @(posedge clk); #1;
        start_b = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int budget, output int dc);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_a) break;
        end
        chk(tag, 32'(done_a), 32'd1);
        dc = cyc;
    endtask

    task automatic wait_done_b(input string tag, input int budget, output int dc);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_b) break;
        end
        chk(tag, 32'(done_b), 32'd1);
        dc = cyc;
    endtask

    initial begin
        int sc, dc, ab, d0, n;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_gray_valid", 32'(gv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_mem_rd_en", 32'(rd_en_a), 32'd0);
        chk("rst_gray", 32'(gray_a), 32'd0);
        chk("rst_row", 32'(row_a), 32'd0);
        chk("rst_col", 32'(col_a), 32'd0);
        chk("rst_markers", 32'({fs_a, le_a, fe_a}), 32'd0);
        chk("rst_b_valid_busy", 32'({gv_b, busy_b}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: full 4x3 frame, gap 3, no backpressure
        ab = acc_a.size(); d0 = done_cnt_a;
        push_frame_a();
        pulse_start_a(sc);
        wait_done_a("t1_done_seen", 300, dc);
        @(negedge clk);
        chk("t1_pixel_count", 32'(acc_a.size() - ab), 32'd12);
        chk("t1_sb_empty", 32'(qa.size()), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        chk("t1_done_width", 32'(done_a), 32'd0);
        chk("t1_busy_after", 32'(busy_a), 32'd0);
        if (acc_a.size() - ab == 12) begin
            chk("t1_start_latency", 32'(acc_a[ab] - sc), 32'd3);
            for (int i = 1; i < 12; i++) chk("t1_spacing", 32'(acc_a[ab + i] - acc_a[ab + i - 1]), 32'd6);
            chk("t1_done_after_last", 32'(dc - acc_a[ab + 11]), 32'd4);
        end

        // 2: out_ready low for 5 cycles while pixel 2 is in SEND
        ab = acc_a.size(); d0 = done_cnt_a;
        push_frame_a();
        pulse_start_a(sc);
        n = 0;
        do begin @(negedge clk); n++; end while (!(rd_en_a && rd_addr_a == 4'd2) && n < 200);
        chk("t2_fetch_px2_seen", 32'(rd_en_a && rd_addr_a == 4'd2), 32'd1);
        @(posedge clk); #1;
        ready_a = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!gv_a && n < 20);
        chk("t2_hold_valid", 32'(gv_a), 32'd1);
        chk("t2_hold_gray", 32'(gray_a), 32'd2);
        chk("t2_hold_col", 32'(col_a), 32'd2);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(gv_a), 32'd1);
            chk("t2_hold_gray", 32'(gray_a), 32'd2);
            chk("t2_hold_col", 32'(col_a), 32'd2);
        end
        @(posedge clk); #1;
        ready_a = 1'b1;
        @(negedge clk);
        chk("t2_sixth_valid", 32'(gv_a), 32'd1);
        chk("t2_sixth_gray", 32'(gray_a), 32'd2);
        wait_done_a("t2_done_seen", 300, dc);
        @(negedge clk);
        chk("t2_pixel_count", 32'(acc_a.size() - ab), 32'd12);
        chk("t2_sb_empty", 32'(qa.size()), 32'd0);
        chk("t2_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        if (acc_a.size() - ab >= 3)
            chk("t2_stalled_spacing", 32'(acc_a[ab + 2] - acc_a[ab + 1]), 32'd11);

        // 3: 2x2 frame, gap 0
        push_frame_b();
        pulse_start_b(sc);
        wait_done_b("t3_done_seen", 100, dc);
        @(negedge clk);
        chk("t3_pixel_count", 32'(acc_b.size()), 32'd4);
        chk("t3_sb_empty", 32'(qb.size()), 32'd0);
        chk("t3_done_pulses", 32'(done_cnt_b), 32'd1);
        chk("t3_read_count", 32'(addr_b.size()), 32'd4);
        if (addr_b.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_read_addr", 32'(addr_b[i]), 32'(i));
        if (acc_b.size() == 4) begin
            chk("t3_start_latency", 32'(acc_b[0] - sc), 32'd3);
            for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(acc_b[i] - acc_b[i - 1]), 32'd3);
            chk("t3_done_after_last", 32'(dc - acc_b[3]), 32'd1);
        end

        // 4: second start while busy at pixel 5 is ignored
        ab = acc_a.size(); d0 = done_cnt_a;
        push_frame_a();
        pulse_start_a(sc);
        n = 0;
        do begin @(negedge clk); n++; end while (!(gv_a && row_a == 16'd1 && col_a == 16'd1) && n < 200);
        chk("t4_px5_seen", 32'(gv_a && row_a == 16'd1 && col_a == 16'd1), 32'd1);
        pulse_start_a(n);
        wait_done_a("t4_done_seen", 300, dc);
        repeat (30) @(negedge clk);
        chk("t4_pixel_count", 32'(acc_a.size() - ab), 32'd12);
        chk("t4_sb_empty", 32'(qa.size()), 32'd0);
        chk("t4_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        chk("t4_busy_after", 32'(busy_a), 32'd0);

        // 5: abort during the gap after pixel 6
        ab = acc_a.size(); d0 = done_cnt_a;
        push_frame_a();
        pulse_start_a(sc);
        n = 0;
        do begin @(negedge clk); n++; end while (!(gv_a && row_a == 16'd1 && col_a == 16'd2) && n < 200);
        chk("t5_px6_seen", 32'(gv_a && row_a == 16'd1 && col_a == 16'd2), 32'd1);
        @(posedge clk); #1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_abort", 32'(busy_a), 32'd0);
        chk("t5_valid_after_abort", 32'(gv_a), 32'd0);
        repeat (20) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt_a - d0), 32'd0);
        chk("t5_pixel_count", 32'(acc_a.size() - ab), 32'd7);
        chk("t5_still_idle", 32'(busy_a), 32'd0);
        qa.delete();

        // Restart after abort begins again at address 0
        push_frame_a();
        pulse_start_a(sc);
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_en_a && n < 20);
        chk("t5_restart_read", 32'(rd_en_a), 32'd1);
        chk("t5_restart_addr", 32'(rd_addr_a), 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!gv_a && n < 20);
        chk("t5_restart_frame_start", 32'(fs_a), 32'd1);
        chk("t5_restart_gray", 32'(gray_a), 32'd0);

        // 6: asynchronous reset while pixel 0 sits in SEND
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_in_reset", 32'(gv_a), 32'd0);
        chk("t6_busy_in_reset", 32'(busy_a), 32'd0);
        chk("t6_rd_en_in_reset", 32'(rd_en_a), 32'd0);
        qa.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        ab = acc_a.size(); d0 = done_cnt_a;
        push_frame_a();
        pulse_start_a(sc);
        wait_done_a("t6_done_seen", 300, dc);
        @(negedge clk);
        chk("t6_pixel_count", 32'(acc_a.size() - ab), 32'd12);
        chk("t6_sb_empty", 32'(qa.size()), 32'd0);
        chk("t6_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        if (acc_a.size() > ab)
            chk("t6_start_latency", 32'(acc_a[ab] - sc), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
